// File: rtl/bios_loader.sv
// rtl/bios_loader.sv - copies SIZE bytes from flash into SD-RAM as 16-bit words after a start pulse.
// Two byte reads (low, high) are packed into one word write; all outputs are registered.
module bios_loader #(
    parameter logic [23:0] SRC_ADDR = 24'h10_0000,
    parameter logic [23:0] DST_ADDR = 24'h70_0000,
    parameter logic [23:0] SIZE     = 24'h02_4000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    output logic        busy,
    output logic        done,
    output logic        flash_rd_req,
    output logic [23:0] flash_addr,
    input  logic        flash_rd_valid,
    input  logic [7:0]  flash_rd_data,
    output logic        ram_wr_req,
    output logic [23:0] ram_addr,
    output logic [15:0] ram_wr_data,
    input  logic        ram_wr_ack
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD_LO,
        S_RD_HI,
        S_WR,
        S_FIN
    } state_t;

    state_t      r_state;
    logic [23:0] r_count;
    logic        r_busy;
    logic        r_done;
    logic        r_flash_rd_req;
    logic [23:0] r_flash_addr;
    logic        r_ram_wr_req;
    logic [23:0] r_ram_addr;
    logic [15:0] r_ram_wr_data;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state        <= S_IDLE;
            r_count        <= '0;
            r_busy         <= 1'b0;
            r_done         <= 1'b0;
            r_flash_rd_req <= 1'b0;
            r_flash_addr   <= '0;
            r_ram_wr_req   <= 1'b0;
            r_ram_addr     <= '0;
            r_ram_wr_data  <= '0;
        end else begin
            case (r_state)
                S_IDLE, S_FIN: begin
                    if (start) begin
                        r_count <= '0;
                        if (SIZE == 24'd0) begin
                            r_state <= S_FIN;
                            r_done  <= 1'b1;
                            r_busy  <= 1'b0;
                        end else begin
                            r_state <= S_RD_LO;
                            r_done  <= 1'b0;
                            r_busy  <= 1'b1;
                        end
                    end
                end
                // Request idles low for one cycle between bytes; a strobe counts only while it is pending.
                S_RD_LO, S_RD_HI: begin
                    if (!r_flash_rd_req) begin
                        r_flash_rd_req <= 1'b1;
                        r_flash_addr   <= SRC_ADDR + r_count;
                    end else if (flash_rd_valid) begin
                        r_flash_rd_req <= 1'b0;
                        r_count        <= r_count + 24'd1;
                        if (r_state == S_RD_LO) begin
                            r_ram_wr_data[7:0] <= flash_rd_data;
                            r_state            <= S_RD_HI;
                        end else begin
                            r_ram_wr_data[15:8] <= flash_rd_data;
                            r_state             <= S_WR;
                        end
                    end
                end
                // Count already includes both bytes of this word, hence the -2.
                S_WR: begin
                    if (!r_ram_wr_req) begin
                        r_ram_wr_req <= 1'b1;
                        r_ram_addr   <= DST_ADDR + r_count - 24'd2;
                    end else if (ram_wr_ack) begin
                        r_ram_wr_req <= 1'b0;
                        if (r_count == SIZE) begin
                            r_state <= S_FIN;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                        end else begin
                            r_state <= S_RD_LO;
                        end
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign busy         = r_busy;
    assign done         = r_done;
    assign flash_rd_req = r_flash_rd_req;
    assign flash_addr   = r_flash_addr;
    assign ram_wr_req   = r_ram_wr_req;
    assign ram_addr     = r_ram_addr;
    assign ram_wr_data  = r_ram_wr_data;

endmodule
